// File: rtl/xadc_channel_scanner.sv
// XADC auxiliary-channel scanner: turns each in-range XADC end-of-conversion
// into one DRP read of that channel's result register and reports the 12-bit
// sample with its VAUX index. It also pulses frame_done once all 13 channels
// (VAUX0..VAUX12) have been refreshed.
// Latency: drp_den is high the cycle after eoc. sample_valid is high the cycle
// after drp_drdy. A read with no drp_drdy times out 64 cycles after drp_den.
// Backpressure: none. An in-range eoc that arrives while a read is in flight
// is dropped and counted in drop_cnt, which saturates at 255.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   eoc, channel        end-of-conversion pulse and its 5-bit channel number
//   drp_den, drp_daddr  DRP read strobe and address {2'b00, channel}
//   drp_do, drp_drdy    DRP read data and data-ready pulse
//   sample_data/_ch     last completed result (drp_do[15:4]) and VAUX index
//   sample_valid        one-cycle qualifier for sample_data/sample_ch
//   frame_done          one-cycle pulse when every VAUX channel has been seen
//   timeout_err         sticky DRP-timeout flag
//   drop_cnt            saturating count of eoc pulses ignored while busy
module xadc_channel_scanner (
   input  logic        clk,
   input  logic        rst,
   input  logic        eoc,
   input  logic [4:0]  channel,
   output logic        drp_den,
   output logic [6:0]  drp_daddr,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic [11:0] sample_data,
   output logic [3:0]  sample_ch,
   output logic        sample_valid,
   output logic        frame_done,
   output logic        timeout_err,
   output logic [7:0]  drop_cnt
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DRDY = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  ch_q;
   logic [5:0]  tmo_cnt;
   logic [12:0] seen;
   logic [12:0] seen_nxt;
   logic        in_range;
   logic        tmo_hit;

   // The low nibble of drp_do is below the 12-bit ADC resolution.
   logic        unused_drp_lsbs;
   assign unused_drp_lsbs = ^drp_do[3:0];

   // VAUX0..VAUX12 live at channel addresses 0x10..0x1C.
   assign in_range = (channel >= 5'h10) && (channel <= 5'h1C);

   // The counter reads 63 in the 64th cycle after drp_den. A drdy in that same
   // cycle still wins over the timeout.
   assign tmo_hit = (state == WAIT_DRDY) && !drp_drdy && (tmo_cnt == 6'd63);

   assign drp_daddr = {2'b00, ch_q};

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (eoc && in_range) state_nxt = REQ;
         REQ:       state_nxt = WAIT_DRDY;
         WAIT_DRDY: begin
            if (drp_drdy)     state_nxt = DONE;
            else if (tmo_hit) state_nxt = IDLE;
         end
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      drp_den      = 1'b0;
      sample_valid = 1'b0;
      frame_done   = 1'b0;
      seen_nxt     = seen;
      case (state)
         REQ:  drp_den = 1'b1;
         DONE: begin
            sample_valid = 1'b1;
            // sample_ch already holds this read's index. A repeated channel
            // leaves the mask unchanged.
            seen_nxt     = seen | (13'd1 << sample_ch);
            frame_done   = &seen_nxt;
         end
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q        <= 5'd0;
         tmo_cnt     <= 6'd0;
         seen        <= 13'd0;
         sample_data <= 12'd0;
         sample_ch   <= 4'd0;
         timeout_err <= 1'b0;
         drop_cnt    <= 8'd0;
      end else begin
         if ((state == IDLE) && eoc && in_range)
            ch_q <= channel;

         if (state == REQ)
            tmo_cnt <= 6'd0;
         else if ((state == WAIT_DRDY) && !drp_drdy)
            tmo_cnt <= tmo_cnt + 6'd1;

         if ((state == WAIT_DRDY) && drp_drdy) begin
            sample_data <= drp_do[15:4];
            sample_ch   <= ch_q[3:0];
         end

         if (tmo_hit)
            timeout_err <= 1'b1;

         if (state == DONE)
            seen <= frame_done ? 13'd0 : seen_nxt;

         if (eoc && in_range && (state != IDLE) && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_xadc_channel_scanner.sv
// Bench for xadc_channel_scanner.
// The bench drives inputs and samples outputs on the falling clock edge.
// Expected values come from a behavioural model made of a seen-channel array,
// a saturating drop tally, and the last sample written.
module tb_xadc_channel_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        eoc;
   logic [4:0]  channel;
   logic        drp_den;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_do;
   logic        drp_drdy;
   logic [11:0] sample_data;
   logic [3:0]  sample_ch;
   logic        sample_valid;
   logic        frame_done;
   logic        timeout_err;
   logic [7:0]  drop_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference-model state.
   int   drops;
   bit   seen_m [13];
   int   dut_frames;
   int   model_frames;
   logic [11:0] last_data;
   logic [3:0]  last_ch;

   xadc_channel_scanner dut (
      .clk          (clk),
      .rst          (rst),
      .eoc          (eoc),
      .channel      (channel),
      .drp_den      (drp_den),
      .drp_daddr    (drp_daddr),
      .drp_do       (drp_do),
      .drp_drdy     (drp_drdy),
      .sample_data  (sample_data),
      .sample_ch    (sample_ch),
      .sample_valid (sample_valid),
      .frame_done   (frame_done),
      .timeout_err  (timeout_err),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Marks a channel as seen. Returns 1 when the frame completes, which also
   // clears every entry.
   function automatic bit model_sample(int idx);
      bit all_seen;
      seen_m[idx] = 1'b1;
      all_seen = 1'b1;
      for (int i = 0; i < 13; i++) if (!seen_m[i]) all_seen = 1'b0;
      if (all_seen) for (int i = 0; i < 13; i++) seen_m[i] = 1'b0;
      return all_seen;
   endfunction

   task automatic model_drop();
      if (drops < 255) drops++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; eoc = 1'b0; drp_drdy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      drops = 0; last_data = '0; last_ch = '0;
      for (int i = 0; i < 13; i++) seen_m[i] = 1'b0;
   endtask

   // One complete read. drp_drdy is asserted dly cycles after the drp_den
   // cycle. Optionally, 'pulses' in-range eoc pulses are issued on alternate
   // cycles while the read is in flight.
   task automatic do_read(input logic [4:0] ch, input int dly, input logic [15:0] d,
                          input int pulses);
      bit fr;
      int idx;
      idx = int'(ch) - 16;
      @(negedge clk);
      eoc = 1'b1; channel = ch;
      @(negedge clk);
      eoc = 1'b0;
      chk("den_after_eoc", {31'd0, drp_den}, 32'd1);
      chk("daddr", {25'd0, drp_daddr}, {25'd0, 2'b00, ch});
      for (int i = 1; i <= dly; i++) begin
         @(negedge clk);
         if (i == 1) chk("den_one_cycle", {31'd0, drp_den}, 32'd0);
         if ((i <= 2 * pulses) && (i % 2 == 1)) begin
            eoc = 1'b1;
            channel = 5'(16 + $urandom_range(0, 12));
            model_drop();
         end else begin
            eoc = 1'b0;
         end
      end
      eoc = 1'b0;
      drp_drdy = 1'b1; drp_do = d;
      @(negedge clk);
      drp_drdy = 1'b0;
      fr = model_sample(idx);
      if (fr) model_frames++;
      last_data = d[15:4]; last_ch = 4'(idx);
      chk("sample_valid", {31'd0, sample_valid}, 32'd1);
      chk("sample_data", {20'd0, sample_data}, {20'd0, last_data});
      chk("sample_ch", {28'd0, sample_ch}, {28'd0, last_ch});
      chk("frame_done", {31'd0, frame_done}, {31'd0, fr});
      chk("drop_cnt", {24'd0, drop_cnt}, drops);
      if (frame_done === 1'b1) dut_frames++;
      @(negedge clk);
      chk("valid_one_cycle", {31'd0, sample_valid}, 32'd0);
      chk("data_hold", {20'd0, sample_data}, {20'd0, last_data});
   endtask

   initial begin
      int perm [13];
      int tmp, j, sv_seen;
      rst = 1'b1; eoc = 1'b0; channel = '0; drp_do = '0; drp_drdy = 1'b0;
      drops = 0; dut_frames = 0; model_frames = 0;
      for (int i = 0; i < 13; i++) seen_m[i] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      last_data = '0; last_ch = '0;

      // Reset state
      chk("rst_den", {31'd0, drp_den}, 32'd0);
      chk("rst_daddr", {25'd0, drp_daddr}, 32'd0);
      chk("rst_data", {20'd0, sample_data}, 32'd0);
      chk("rst_ch", {28'd0, sample_ch}, 32'd0);
      chk("rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_frame", {31'd0, frame_done}, 32'd0);
      chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
      chk("rst_drop", {24'd0, drop_cnt}, 32'd0);

      // Directed read: channel 0x13, drdy 3 cycles after den, data 0xABC0
      do_read(5'h13, 3, 16'hABC0, 0);
      chk("directed_data", {20'd0, sample_data}, 32'hABC);
      chk("directed_ch", {28'd0, sample_ch}, 32'd3);

      // Out-of-range channels are neither read nor counted
      @(negedge clk); eoc = 1'b1; channel = 5'h03;
      @(negedge clk); eoc = 1'b0;
      chk("oor_no_den", {31'd0, drp_den}, 32'd0);
      chk("oor_drop", {24'd0, drop_cnt}, drops);
      @(negedge clk); eoc = 1'b1; channel = 5'h1D;
      @(negedge clk); eoc = 1'b0;
      chk("oor1d_no_den", {31'd0, drp_den}, 32'd0);
      chk("oor1d_drop", {24'd0, drop_cnt}, drops);

      // drp_drdy outside WAIT_DRDY is ignored
      @(negedge clk); drp_drdy = 1'b1; drp_do = 16'h5555;
      @(negedge clk); drp_drdy = 1'b0;
      chk("idle_drdy_valid", {31'd0, sample_valid}, 32'd0);
      @(negedge clk);
      chk("idle_drdy_valid2", {31'd0, sample_valid}, 32'd0);
      chk("idle_drdy_data", {20'd0, sample_data}, {20'd0, last_data});

      // Random-order full frame starting from an empty mask. The first read
      // uses the latest accepted drdy (the timeout-expiry cycle).
      do_reset();
      dut_frames = 0; model_frames = 0;
      for (int i = 0; i < 13; i++) perm[i] = i;
      for (int i = 12; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < 13; i++)
         do_read(5'(16 + perm[i]), (i == 0) ? 64 : $urandom_range(1, 64),
                 16'($urandom), 0);
      chk("frame_once", dut_frames, 32'd1);
      chk("frame_model_once", model_frames, 32'd1);
      chk("edge_drdy_no_tmo", {31'd0, timeout_err}, 32'd0);

      // A repeated channel leaves the mask unchanged.
      dut_frames = 0;
      do_read(5'h10, $urandom_range(1, 10), 16'($urandom), 0);
      do_read(5'h10, $urandom_range(1, 10), 16'($urandom), 0);
      for (int i = 1; i < 13; i++)
         do_read(5'(16 + i), $urandom_range(1, 10), 16'($urandom), 0);
      chk("repeat_frame_once", dut_frames, 32'd1);

      // Timeout: drdy withheld
      @(negedge clk); eoc = 1'b1; channel = 5'h15;
      @(negedge clk); eoc = 1'b0;
      chk("tmo_den", {31'd0, drp_den}, 32'd1);
      sv_seen = 0;
      repeat (64) begin
         @(negedge clk);
         if (sample_valid === 1'b1) sv_seen++;
      end
      chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
      @(negedge clk);
      if (sample_valid === 1'b1) sv_seen++;
      chk("tmo_set", {31'd0, timeout_err}, 32'd1);
      chk("tmo_no_sample", sv_seen, 32'd0);
      do_read(5'(16 + $urandom_range(0, 12)), $urandom_range(1, 20), 16'($urandom), 0);
      chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);

      // Drop counter saturation: 300 in-range eocs while busy
      for (int r = 0; r < 10; r++)
         do_read(5'(16 + $urandom_range(0, 12)), 62, 16'($urandom), 30);
      chk("drop_saturated", {24'd0, drop_cnt}, 32'd255);

      // Reset during WAIT_DRDY, with an eoc in the same cycle, then a late drdy
      @(negedge clk); eoc = 1'b1; channel = 5'h18;
      @(negedge clk); eoc = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1; eoc = 1'b1; channel = 5'h11;
      @(negedge clk);
      rst = 1'b0; eoc = 1'b0;
      drops = 0; last_data = '0; last_ch = '0;
      for (int i = 0; i < 13; i++) seen_m[i] = 1'b0;
      chk("rstmid_no_den", {31'd0, drp_den}, 32'd0);
      drp_drdy = 1'b1; drp_do = 16'hFFF0;
      @(negedge clk);
      drp_drdy = 1'b0;
      chk("rstmid_valid", {31'd0, sample_valid}, 32'd0);
      chk("rstmid_den", {31'd0, drp_den}, 32'd0);
      chk("rstmid_daddr", {25'd0, drp_daddr}, 32'd0);
      chk("rstmid_data", {20'd0, sample_data}, 32'd0);
      chk("rstmid_ch", {28'd0, sample_ch}, 32'd0);
      chk("rstmid_frame", {31'd0, frame_done}, 32'd0);
      chk("rstmid_tmo", {31'd0, timeout_err}, 32'd0);
      chk("rstmid_drop", {24'd0, drop_cnt}, 32'd0);
      @(negedge clk);
      chk("rstmid_valid2", {31'd0, sample_valid}, 32'd0);

      // The scanner is still usable after the abort.
      do_read(5'h1C, 2, 16'h1230, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xadc_channel_scanner.md
XADC_CHANNEL_SCANNER -- requirements
Module: xadc_channel_scanner

Interface
REQ-001 SHALL: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset, driven by the internal reset stage.
REQ-003 SHALL: eoc  input  1  XADC end-of-conversion pulse, one cycle wide.
REQ-004 SHALL: channel  input  5  XADC channel number, valid while eoc=1.
REQ-005 SHALL: drp_den  output  1  DRP enable, one-cycle pulse per read.
REQ-006 SHALL: drp_daddr  output  7  DRP address, equal to {2'b00, latched channel}.
REQ-007 SHALL: drp_do  input  16  DRP read data from XADC.
REQ-008 SHALL: drp_drdy  input  1  DRP data-ready pulse.
REQ-009 SHALL: sample_data  output  12  result, drp_do[15:4] of the completed read.
REQ-010 SHALL: sample_ch  output  4  channel index 0..12 of sample_data.
REQ-011 SHALL: sample_valid  output  1  one-cycle pulse qualifying sample_data and sample_ch.
REQ-012 SHALL: frame_done  output  1  one-cycle pulse when all 13 channels have been updated.
REQ-013 SHALL: timeout_err  output  1  sticky flag, set on DRP timeout.
REQ-014 SHALL: drop_cnt  output  8  saturating count of ignored eoc pulses.

Function
REQ-015 SHALL: channel addresses 0x10..0x1C (VAUX0..VAUX12) map to index = channel-0x10; all other channels are out of range.
REQ-016 SHALL: the FSM has exactly the states IDLE, REQ, WAIT_DRDY and DONE.
REQ-017 SHALL: IDLE, eoc=1 with in-range channel -> latch channel, go to REQ; with out-of-range channel -> stay in IDLE, no count.
REQ-018 SHALL: REQ -> drive drp_den=1 for exactly one cycle with drp_daddr valid, clear the timeout counter, go to WAIT_DRDY (drp_den high the cycle after the eoc).
REQ-019 SHALL: WAIT_DRDY, drp_drdy=1 -> capture drp_do[15:4] and the index, go to DONE.
REQ-020 SHALL: WAIT_DRDY, 64 cycles after drp_den without drp_drdy -> set timeout_err, go to IDLE, produce no sample_valid.
REQ-021 SHALL: DONE -> sample_valid=1 for one cycle (the cycle after drp_drdy) and set bit[index] of the 13-bit seen mask, then go to IDLE.
REQ-022 SHALL: when the seen mask becomes all-ones, frame_done pulses in the same cycle as that sample_valid and the mask clears to zero.
REQ-023 SHALL: drop_cnt increments by one for each in-range eoc that arrives while the state is not IDLE, and holds at 255.
REQ-024 SHALL: drp_drdy is ignored outside WAIT_DRDY.
REQ-025 SHALL: a repeated channel within a frame updates sample_data and sample_valid normally and leaves the mask unchanged.
REQ-026 SHALL: sample_data and sample_ch hold their last value between sample_valid pulses.
REQ-027 SHALL: a drp_drdy arriving in the same cycle as the timeout expiry is accepted, and timeout_err is not set.

Reset
REQ-028 SHALL: rst=1 -> state IDLE, drp_den=0, drp_daddr=0, sample_data=0, sample_ch=0, sample_valid=0, frame_done=0, timeout_err=0, drop_cnt=0, seen mask=0, timeout counter=0.
REQ-029 SHALL: rst asserted mid-transaction aborts the read; a drp_drdy arriving after rst deasserts is ignored (state IDLE).
REQ-030 SHALL: rst has priority over every other input in the same cycle.

Verification
REQ-031 SHALL: eoc with channel=0x13, drp_drdy 3 cycles after drp_den, drp_do=0xABC0 -> drp_daddr=0x13, then sample_valid with sample_data=0xABC, sample_ch=3.
REQ-032 SHALL: 13 reads covering channels 0x10..0x1C in random order -> frame_done pulses once, coincident with the 13th sample_valid.
REQ-033 SHALL: eoc with channel=0x03 (out of range) -> no drp_den, drop_cnt unchanged.
REQ-034 SHALL: drp_drdy withheld -> timeout_err=1 at 64 cycles, FSM back in IDLE; the next eoc is serviced normally and timeout_err stays 1.
REQ-035 SHALL: 300 in-range eoc pulses during WAIT_DRDY -> drop_cnt saturates at 255.
REQ-036 SHALL: rst pulsed while in WAIT_DRDY, followed by a late drp_drdy -> no sample_valid, and all outputs at their reset values.
